fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 23 ++
 rtl/fetch_buffer.sv | 57 +++++
 rtl/fetch_unit.sv | 131 +++++++++++++
 tb/tb_fetch_unit.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types for the instruction fetch unit.
// JZJCOREF_FETCH_PREFETCH_BUFFER_EN selects a 2-entry prefetch FIFO instead of a single register.
package JZJCoreFTypes;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        DISCARD = 2'd2,
        HALT    = 2'd3
    } FetchState;

    typedef struct packed {
        logic [31:0] instruction;
        logic [31:0] pc;
    } FetchEntry;

`ifdef JZJCOREF_FETCH_PREFETCH_BUFFER_EN
    localparam int FETCH_BUFFER_DEPTH = 2;
`else
    localparam int FETCH_BUFFER_DEPTH = 1;
`endif

endpackage

// File: rtl/fetch_buffer.sv
// Shift-register FIFO holding fetched {instruction, pc} entries; entry 0 is the head.
// Depth follows JZJCOREF_FETCH_PREFETCH_BUFFER_EN through FETCH_BUFFER_DEPTH.
module fetch_buffer
    import JZJCoreFTypes::*;
#(
    parameter int DEPTH = FETCH_BUFFER_DEPTH,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic      clock,
    input  logic      reset,
    input  logic      push,
    input  logic      pop,
    input  logic      flush,
    input  FetchEntry pushEntry,
    output FetchEntry headEntry,
    output logic      full,
    output logic      almostFull,
    output logic      empty,
    output logic      spaceAvailable
);

    FetchEntry     entries [DEPTH];
    logic [CW-1:0] occupancy;
    logic [CW-1:0] writeIdx;

    // A simultaneous pop shifts everything down, so the new word lands one slot lower.
    assign writeIdx       = pop ? (occupancy - CW'(1)) : occupancy;
    assign headEntry      = entries[0];
    assign empty          = (occupancy == CW'(0));
    assign full           = (occupancy == CW'(DEPTH));
    assign almostFull     = (occupancy == CW'(DEPTH - 1));
    assign spaceAvailable = !full;

    // Storage and occupancy update; flush only clears occupancy, stale data is never visible.
    always_ff @(posedge clock) begin
        if (!reset) begin
            occupancy <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else if (flush) begin
            occupancy <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (push && (CW'(i) == writeIdx)) begin
                    entries[i] <= pushEntry;
                end else if (pop) begin
                    entries[i] <= entries[(i + 1) % DEPTH];
                end else begin
                    entries[i] <= entries[i];
                end
            end
            occupancy <= occupancy + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: fetch FSM and PC feeding a prefetch buffer towards the decoder.
// Buffer depth is selected by JZJCOREF_FETCH_PREFETCH_BUFFER_EN (see JZJCoreFTypes).
module fetch_unit
    import JZJCoreFTypes::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h00000000
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] memAddr,
    output logic        memReq,
    input  logic        memAck,
    input  logic [31:0] memData,
    output logic [31:0] instruction,
    output logic        instructionValid,
    output logic [31:0] instructionPC,
    input  logic        advance,
    input  logic        redirect,
    input  logic [31:0] redirectAddress,
    output logic        fetchFault
);

    FetchState   state;
    logic [31:0] fetchPC;
    FetchEntry   pushEntry;
    FetchEntry   headEntry;
    logic        bufFull;
    logic        bufAlmostFull;
    logic        bufEmpty;
    logic        bufSpace;
    logic        redirectTaken;
    logic        misaligned;
    logic        outstanding;
    logic        doPush;
    logic        doPop;
    logic        spaceAfterPush;

    assign redirectTaken    = redirect && !fetchFault;
    assign misaligned       = (redirectAddress[1:0] != 2'b00);
    assign outstanding      = memReq && !memAck;
    assign doPush           = (state == REQUEST) && memReq && memAck && !redirectTaken;
    assign doPop            = advance && !bufEmpty && !redirectTaken;
    // The slot for the in-flight request is already reserved, so stay only if another remains.
    assign spaceAfterPush   = doPop || !(bufFull || bufAlmostFull);
    assign pushEntry        = '{instruction: memData, pc: memAddr};
    assign instruction      = headEntry.instruction;
    assign instructionPC    = headEntry.pc;
    assign instructionValid = !bufEmpty;

    fetch_buffer u_fetch_buffer (
        .clock          (clock),
        .reset          (reset),
        .push           (doPush),
        .pop            (doPop),
        .flush          (redirectTaken),
        .pushEntry      (pushEntry),
        .headEntry      (headEntry),
        .full           (bufFull),
        .almostFull     (bufAlmostFull),
        .empty          (bufEmpty),
        .spaceAvailable (bufSpace)
    );

    // Fetch FSM; memAddr only moves when no request is waiting for its acknowledge.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            fetchPC    <= RESET_VECTOR;
            memAddr    <= RESET_VECTOR;
            memReq     <= 1'b0;
            fetchFault <= 1'b0;
        end else if (redirectTaken) begin
            if (misaligned) begin
                fetchFault <= 1'b1;
                state      <= outstanding ? DISCARD : HALT;
                memReq     <= outstanding;
            end else begin
                fetchPC <= redirectAddress;
                state   <= outstanding ? DISCARD : REQUEST;
                memReq  <= 1'b1;
                if (!outstanding) begin
                    memAddr <= redirectAddress;
                end else begin
                    memAddr <= memAddr;
                end
            end
        end else begin
            case (state)
                IDLE: begin
                    if (!fetchFault && (bufSpace || doPop)) begin
                        state  <= REQUEST;
                        memReq <= 1'b1;
                    end else begin
                        state  <= IDLE;
                        memReq <= 1'b0;
                    end
                end
                REQUEST: begin
                    if (memAck) begin
                        fetchPC <= fetchPC + 32'd4;
                        memAddr <= fetchPC + 32'd4;
                        state   <= spaceAfterPush ? REQUEST : IDLE;
                        memReq  <= spaceAfterPush;
                    end else begin
                        state  <= REQUEST;
                        memReq <= 1'b1;
                    end
                end
                DISCARD: begin
                    if (memAck) begin
                        memAddr <= fetchPC;
                        state   <= fetchFault ? HALT : REQUEST;
                        memReq  <= !fetchFault;
                    end else begin
                        state  <= DISCARD;
                        memReq <= 1'b1;
                    end
                end
                HALT: begin
                    state  <= HALT;
                    memReq <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    memReq <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit with a latency-configurable memory model and PC scoreboard.
module tb_fetch_unit;

`ifdef JZJCOREF_FETCH_PREFETCH_BUFFER_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] memAddr, memData, instruction, instructionPC, redirectAddress;
    logic        memReq, memAck, instructionValid, advance, redirect, fetchFault;

    logic [31:0] memAddr2, memData2, instruction2, instructionPC2, redirectAddress2;
    logic        memReq2, memAck2, instructionValid2, advance2, redirect2, fetchFault2;

    int checks = 0;
    int errors = 0;
    int latency = 0;
    int waitCnt = 0;
    int ackCount = 0;
    logic [31:0] expQ [$];

    always #5 clock = ~clock;

    fetch_unit dut (
        .clock(clock), .reset(reset), .memAddr(memAddr), .memReq(memReq), .memAck(memAck),
        .memData(memData), .instruction(instruction), .instructionValid(instructionValid),
        .instructionPC(instructionPC), .advance(advance), .redirect(redirect),
        .redirectAddress(redirectAddress), .fetchFault(fetchFault)
    );

    fetch_unit #(.RESET_VECTOR(32'hFFFFFFFC)) dut2 (
        .clock(clock), .reset(reset), .memAddr(memAddr2), .memReq(memReq2), .memAck(memAck2),
        .memData(memData2), .instruction(instruction2), .instructionValid(instructionValid2),
        .instructionPC(instructionPC2), .advance(advance2), .redirect(redirect2),
        .redirectAddress(redirectAddress2), .fetchFault(fetchFault2)
    );

    function automatic logic [31:0] word(input logic [31:0] a);
        return 32'h00000013 | (a << 8);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock; memory acks after 'latency' waiting cycles of an asserted memReq.
    task automatic tick();
        @(posedge clock);
        #1;
        if (memReq === 1'b1) begin
            if (waitCnt >= latency) begin
                memAck  = 1'b1;
                memData = word(memAddr);
                waitCnt = 0;
                ackCount++;
            end else begin
                memAck = 1'b0;
                waitCnt++;
            end
        end else begin
            memAck  = 1'b0;
            waitCnt = 0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0; advance = 1'b0; redirect = 1'b0; redirectAddress = 32'h0;
        memAck = 1'b0; memData = 32'h0;
        tick();
        tick();
        chk("rst_memReq", 32'(memReq), 32'd0);
        chk("rst_valid", 32'(instructionValid), 32'd0);
        chk("rst_fault", 32'(fetchFault), 32'd0);
        chk("rst_instr", instruction, 32'h0);
        chk("rst_pc", instructionPC, 32'h0);
        chk("rst_addr", memAddr, 32'h0);
        chk("rst_addr2", memAddr2, 32'hFFFFFFFC);
        expQ.delete();
        ackCount = 0;
        waitCnt  = 0;
        reset = 1'b1;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (instructionValid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, 32'(instructionValid), 32'd1);
    endtask

    // Pop the scoreboard and compare it against the head, then consume the head.
    task automatic consume(input string tag);
        logic [31:0] pc;
        wait_valid(tag);
        chk({tag, "_sbq"}, 32'(expQ.size() != 0), 32'd1);
        pc = (expQ.size() != 0) ? expQ.pop_front() : 32'hDEADBEEF;
        chk({tag, "_pc"}, instructionPC, pc);
        chk({tag, "_instr"}, instruction, word(pc));
        advance = 1'b1;
        tick();
        advance = 1'b0;
    endtask

    initial begin
        int n;
        memAck2 = 1'b1; memData2 = 32'h00000013; advance2 = 1'b1;
        redirect2 = 1'b0; redirectAddress2 = 32'h0;

        // Reset release, one-cycle memory latency, first word and address increment.
        latency = 1;
        do_reset();
        expQ.push_back(32'h0);
        tick();
        chk("t1_req", 32'(memReq), 32'd1);
        chk("t1_addr0", memAddr, 32'h0);
        chk("t1_req2", 32'(memReq2), 32'd1);
        chk("t1_addr2_first", memAddr2, 32'hFFFFFFFC);
        tick();
        chk("t1_addr_ack", memAddr, 32'h0);
        chk("t1_addr2_wrap", memAddr2, 32'h0);
        chk("t1_valid2", 32'(instructionValid2), 32'd1);
        chk("t1_pc2", instructionPC2, 32'hFFFFFFFC);
        chk("t1_fault2", 32'(fetchFault2), 32'd0);
        tick();
        chk("t1_valid", 32'(instructionValid), 32'd1);
        chk("t1_pc", instructionPC, 32'h0);
        chk("t1_instr", instruction, 32'h00000013);
        chk("t1_addr4", memAddr, 32'h4);
        consume("t1");

        // Advance held low with zero-latency memory: buffer fills then requests stop.
        latency = 0;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            tick();
        end
        chk("t2_acks", 32'(ackCount), 32'(DEPTH));
        chk("t2_req_low", 32'(memReq), 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            expQ.push_back(32'(4 * i));
        end
        for (int i = 0; i < DEPTH; i++) begin
            consume("t2");
        end

        // Redirect while a 3-cycle request is outstanding: stale word dropped.
        latency = 3;
        do_reset();
        tick();
        redirect = 1'b1; redirectAddress = 32'h00000100;
        expQ.push_back(32'h00000100);
        tick();
        redirect = 1'b0;
        chk("t3_addr_hold", memAddr, 32'h0);
        chk("t3_req_hold", 32'(memReq), 32'd1);
        chk("t3_flushed", 32'(instructionValid), 32'd0);
        n = 0;
        while (memAck !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        chk("t3_stale_ack", 32'(memAck), 32'd1);
        chk("t3_stale_addr", memAddr, 32'h0);
        tick();
        chk("t3_new_addr", memAddr, 32'h00000100);
        chk("t3_dropped", 32'(instructionValid), 32'd0);
        consume("t3");

        // Redirect and advance together with a full buffer.
        latency = 0;
        do_reset();
        n = 0;
        tick();
        while (memReq === 1'b1 && n < 10) begin
            tick();
            n++;
        end
        chk("t4_full_idle", 32'(memReq), 32'd0);
        redirect = 1'b1; redirectAddress = 32'h00000200; advance = 1'b1;
        expQ.push_back(32'h00000200);
        tick();
        redirect = 1'b0; advance = 1'b0;
        chk("t4_empty", 32'(instructionValid), 32'd0);
        chk("t4_addr", memAddr, 32'h00000200);
        chk("t4_req", 32'(memReq), 32'd1);
        consume("t4");

        // Misaligned redirect with a pending request: sticky fault, then halt.
        latency = 2;
        do_reset();
        tick();
        redirect = 1'b1; redirectAddress = 32'h00000102;
        tick();
        redirect = 1'b0;
        chk("t5_fault", 32'(fetchFault), 32'd1);
        chk("t5_valid", 32'(instructionValid), 32'd0);
        chk("t5_req_pending", 32'(memReq), 32'd1);
        n = 0;
        while (memAck !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        tick();
        chk("t5_halt_req", 32'(memReq), 32'd0);
        redirect = 1'b1; redirectAddress = 32'h00000300;
        tick();
        redirect = 1'b0;
        tick();
        tick();
        chk("t5_ignored_req", 32'(memReq), 32'd0);
        chk("t5_ignored_addr", memAddr, 32'h0);
        chk("t5_sticky", 32'(fetchFault), 32'd1);
        chk("t5_still_empty", 32'(instructionValid), 32'd0);

        // Streaming with concurrent push and pop.
        latency = 0;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            expQ.push_back(32'(4 * i));
        end
        for (int i = 0; i < 8; i++) begin
            consume("t6");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
